// File: rtl/fetch_issue_pkg.sv
// Shared CPU constants for the fetch/issue front end.
// Latency: n/a (constants, types and a pure helper only).
// Backpressure: n/a.
package fetch_issue_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP       = '0;

    // RUN: no redirect outstanding; REDIR: a target is waiting for the delay slot to issue
    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } redir_state_t;

    // Word-align an address; instruction fetch never uses the low two bits
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_issue_redirect_latch.sv
// Holds a branch target seen while its delay slot has not yet been fetched.
// Latency: target visible on pend_tgt_o the cycle after set_i.
// Backpressure: caller gates set_i/clr_i; the latch itself never stalls.
module redirect_latch
    import fetch_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  logic [31:0] tgt_i,
    input  logic        clr_i,
    output logic        pending_o,
    output logic [31:0] pend_tgt_o
);

    redir_state_t state_q, state_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;

    // State and target registers; reset drops any outstanding redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Next state: capture the first target only; later ones are ignored until the slot issues
    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        unique case (state_q)
            RUN: begin
                if (set_i) begin
                    state_d    = REDIR;
                    pend_tgt_d = align_word(tgt_i);
                end
            end
            REDIR: begin
                if (clr_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign pending_o  = (state_q == REDIR);
    assign pend_tgt_o = pend_tgt_q;

endmodule

// File: rtl/fetch_issue.sv
// Instruction fetch and issue to decode with a single branch delay slot.
// Latency: instruction appears on D_* one cycle after the accepting im_ack.
// Backpressure: stall freezes PC and D; a missing im_ack inserts a bubble.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic               im_req,
    output logic [31:0]        im_addr,
    input  logic               im_ack,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [INSTR_W-1:0] D_I,
    output logic [31:0]        D_PC,
    output logic               D_valid
);

    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] d_i_q, d_i_d;
    logic [31:0]        d_pc_q, d_pc_d;
    logic               d_valid_q, d_valid_d;

    logic               adv;
    logic               miss;
    logic               pending;
    logic [31:0]        pend_tgt;

    // A fetch is requested whenever out of reset and not held by a hazard
    assign im_req  = reset & ~stall;
    assign im_addr = pc_q;
    assign adv     = im_req & im_ack;
    assign miss    = im_req & ~im_ack;

    // A branch seen during a miss must wait: its delay slot has not been fetched yet
    redirect_latch u_redirect_latch (
        .clk        (clk),
        .rst_n      (reset),
        .set_i      (miss & br_taken & ~pending),
        .tgt_i      (br_target),
        .clr_i      (adv),
        .pending_o  (pending),
        .pend_tgt_o (pend_tgt)
    );

    // PC and decode-stage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= align_word(RESET_PC);
            d_i_q     <= NOP;
            d_pc_q    <= '0;
            d_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            d_i_q     <= d_i_d;
            d_pc_q    <= d_pc_d;
            d_valid_q <= d_valid_d;
        end
    end

    // Issue on accept, bubble on miss, hold everything on stall
    always_comb begin
        pc_d      = pc_q;
        d_i_d     = d_i_q;
        d_pc_d    = d_pc_q;
        d_valid_d = d_valid_q;
        if (adv) begin
            d_i_d     = im_rdata;
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
            if (pending) begin
                pc_d = pend_tgt;
            end else if (br_taken) begin
                pc_d = align_word(br_target);
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (miss) begin
            d_i_d     = NOP;
            d_pc_d    = '0;
            d_valid_d = 1'b0;
        end
    end

    assign D_I     = d_i_q;
    assign D_PC    = d_pc_q;
    assign D_valid = d_valid_q;

endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port stall  input  1  meaning a hazard hold of the F and D stages.
REQ-005 SHALL have port br_taken  input  1  meaning the branch/jump in D redirects control flow.
REQ-006 SHALL have port br_target  input  32  meaning the redirect destination from D.
REQ-007 SHALL have port im_req  output  1  meaning an instruction-memory read request.
REQ-008 SHALL have port im_addr  output  32  meaning the instruction-memory read address (current PC).
REQ-009 SHALL have port im_ack  input  1  meaning the memory has returned data this cycle.
REQ-010 SHALL have port im_rdata  input  32  meaning the instruction word, valid when im_ack=1.
REQ-011 SHALL have port D_I  output  32  meaning the instruction issued to D, registered.
REQ-012 SHALL have port D_PC  output  32  meaning the PC of D_I, registered.
REQ-013 SHALL have port D_valid  output  1  meaning D_I is a real instruction, not a bubble.

Function
REQ-014 SHALL drive im_addr = PC and im_req = !stall, combinationally.
REQ-015 SHALL define adv = im_req & im_ack, and on adv load D_I<=im_rdata, D_PC<=PC, D_valid<=1, with 1-cycle latency from ack to D.
REQ-016 SHALL set next PC on adv as follows, in priority order: pending target (clear pending), then br_target if br_taken in the same cycle, then PC+4.
REQ-017 SHALL treat the word fetched in the cycle a redirect is seen as the delay slot, so it always issues before the target.
REQ-018 SHALL, when !stall & !im_ack, hold PC and insert a bubble (D_I<=0, D_PC<=0, D_valid<=0).
REQ-019 SHALL, in the same cycle as REQ-018, latch br_target into pend_tgt and set pending when br_taken=1 and pending=0.
REQ-020 SHALL ignore br_taken while pending=1; a branch in a delay slot is illegal, and the first target wins.
REQ-021 SHALL, when stall=1, hold PC, D_I, D_PC, D_valid, pending and pend_tgt, and ignore br_taken and im_ack.
REQ-022 SHALL force bits [1:0] of PC and of any loaded target to 0.
REQ-023 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-024 SHALL, while reset=0 and independent of clk, set PC=RESET_PC, D_I=0, D_PC=0, D_valid=0, pending=0, pend_tgt=0.
REQ-025 SHALL drive im_req=0 while reset=0.
REQ-026 SHALL begin fetching RESET_PC on the first rising edge after reset returns to 1.
REQ-027 SHALL discard any pending redirect or in-flight fetch when reset is asserted mid-operation.

Structure
REQ-028 SHALL take RESET_PC default, the NOP encoding (32'h0) and the instruction width from the shared CPU constants package.
REQ-029 SHALL implement the pending-redirect register (pending, pend_tgt) as one sub-module named redirect_latch; the rest is flat.
REQ-030 SHALL keep the control states explicit: RUN (pending=0) and REDIR (pending=1); RUN->REDIR per REQ-019, REDIR->RUN on adv.

Verification
REQ-031 SHALL cover straight-line fetch: im_ack=1, im_rdata=addr after reset release -> D_PC 0x3000, 0x3004, 0x3008 on successive edges, D_valid=1 throughout.
REQ-032 SHALL cover same-cycle redirect: br_taken=1, br_target=0x3100 while fetching 0x3008 with ack -> D_PC 0x3008, then 0x3100.
REQ-033 SHALL cover late ack with redirect: br_taken=1, target 0x3100 at 0x3008 with ack=0 for 2 cycles -> 2 bubbles (D_valid=0, D_I=0), then D_PC 0x3008, then 0x3100.
REQ-034 SHALL cover stall: stall=1 for 3 cycles with br_taken=1 and ack=1 -> im_req=0, and D_I, D_PC and PC unchanged; fetch resumes from the same PC afterwards.
REQ-035 SHALL cover reset during REDIR: reset=0 asynchronously -> outputs 0 immediately, pending=0, next fetch 0x3000.
REQ-036 SHALL cover wrap: target 0xFFFF_FFFE -> fetch 0xFFFF_FFFC, then 0x0000_0000.
